mult_arbiter: RTL and testbench
===============================

// Module: mult_arbiter
// PURPOSE
//  Shares one sequential shift-add multiplier among NUM_REQ requesters.
//  Requests are arbitrated round-robin. The winner's operands are latched, a start
//  pulse is issued to the multiplier, and the block waits for its valid. The 2*DATA_WIDTH
//  product is then returned to the winner with a one-cycle done pulse.
//  A watchdog aborts a job with an error flag if the multiplier never answers.
// PARAMETERS
//  DATA_WIDTH  5   operand width; product is 2*DATA_WIDTH
//  NUM_REQ     4   number of requesters (>=2)
//  TIMEOUT     64  max cycles waited in WAIT before abort (>=2*DATA_WIDTH+4)
// PORTS
//  CLK        in   1                     clock, rising edge
//  RST        in   1                     asynchronous reset, active-high
//  req        in   NUM_REQ               level request per requester
//  req_op1    in   NUM_REQ*DATA_WIDTH    operand 1, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//  req_op2    in   NUM_REQ*DATA_WIDTH    operand 2, same packing
//  gnt        out  NUM_REQ               one-hot, 1-cycle grant (operands taken)
//  done       out  NUM_REQ               one-hot, 1-cycle completion to the granted requester
//  result     out  2*DATA_WIDTH          product of last job, held until next done
//  err        out  1                     qualifies done: 1 = timed out, result forced 0
//  busy       out  1                     1 in every state except IDLE
//  mul_start  out  1                     1-cycle start pulse to the multiplier
//  mul_op1    out  DATA_WIDTH            latched operand 1, stable from ISSUE through WAIT
//  mul_op2    out  DATA_WIDTH            latched operand 2
//  mul_result in   2*DATA_WIDTH          multiplier product
//  mul_valid  in   1                     multiplier result-valid
// BEHAVIOUR
//  Reset (async, any state): state=IDLE.
//   gnt, done, err, busy, mul_start, result, mul_op1 and mul_op2 all 0.
//   Timeout counter 0. RR pointer last=NUM_REQ-1, so requester 0 has top priority.
//  FSM (Moore outputs, registered state): IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  IDLE:  busy=0.
//   If req!=0 at the edge: pick the first set bit searching last+1, last+2, ... (mod NUM_REQ).
//   Latch its operands into mul_op1/mul_op2, store its index, go ISSUE.
//   If req==0: stay.
//  ISSUE (1 cycle): gnt[idx]=1, mul_start=1; clear counter; go WAIT.
//   mul_valid is ignored in ISSUE.
//  WAIT: counter increments each cycle.
//   If mul_valid=1: capture mul_result into result, err<=0, go RESP.
//   Else if counter==TIMEOUT-1: result<=0, err<=1, go RESP.
//   mul_valid takes priority over timeout in the same cycle.
//  RESP (1 cycle): done[idx]=1; result/err valid; last<=idx; go IDLE.
//  Latency: req sampled in IDLE at edge k -> gnt/mul_start high in cycle k..k+1.
//   If mul_valid is first seen at edge m, done is high in cycle m..m+1.
//   Minimum IDLE-to-IDLE turnaround is 4 cycles.
//  Requester rules:
//   - Operands must be valid while req=1.
//   - The requester deasserts req on seeing gnt.
//   - If req is still high in the next IDLE, it is re-arbitrated as a new job, at lowest priority.
//   - req changes during ISSUE/WAIT/RESP are ignored; no queueing inside the block.
//  err and result hold their values after RESP until overwritten by the next RESP.
//   err is meaningful only with done.
//  mul_valid outside WAIT is ignored (no effect on state or result).
//  Widths: idx is $clog2(NUM_REQ) bits. Counter is $clog2(TIMEOUT+1) bits and never wraps
//   (cleared in ISSUE).
// TESTING
//  1. Multiplier model with latency 10. req[0], op 3*7 -> gnt[0] 1 cycle after req.
//     Then done[0] with result=21, err=0; busy high from ISSUE through RESP.
//  2. req=4'b1111 held continuously -> grant order 0,1,2,3,0.
//     Each done matches the requester's own op1*op2.
//  3. req[0] and req[2] held, ops 31*31 and 0*17 -> alternate grants 0,2,0.
//     Results 961 and 0.
//  4. Multiplier never asserts mul_valid -> done[idx]=1 and err=1 with result=0,
//     exactly TIMEOUT cycles after entering WAIT.
//  5. Spurious mul_valid in IDLE and ISSUE -> no state change. result is updated only in WAIT.
//  6. RST pulsed mid-WAIT -> all outputs 0 immediately.
//     Next req[1] is granted ahead of req[2] per the reset pointer.

Source files
------------

// File: rtl/mult_arbiter.sv
// ============================================================================
// Module   : mult_arbiter
// Purpose  : Round-robin sharing of one sequential multiplier among NUM_REQ
//            requesters, with a watchdog that aborts unanswered jobs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_arbiter #(
    parameter int DATA_WIDTH = 5,
    parameter int NUM_REQ    = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_op1,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_op2,
    output logic [NUM_REQ-1:0]              gnt,
    output logic [NUM_REQ-1:0]              done,
    output logic [2*DATA_WIDTH-1:0]         result,
    output logic                            err,
    output logic                            busy,
    output logic                            mul_start,
    output logic [DATA_WIDTH-1:0]           mul_op1,
    output logic [DATA_WIDTH-1:0]           mul_op2,
    input  logic [2*DATA_WIDTH-1:0]         mul_result,
    input  logic                            mul_valid
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_RESP  = 2'd3;

    localparam logic [IDX_W:0]   c_NUM      = (IDX_W+1)'(NUM_REQ);
    localparam logic [CNT_W-1:0] c_TMO_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_last;
    logic [CNT_W-1:0] r_cnt;

    logic [DATA_WIDTH-1:0] w_op1 [NUM_REQ];
    logic [DATA_WIDTH-1:0] w_op2 [NUM_REQ];
    logic [NUM_REQ-1:0]    w_idx_oh;
    logic                  w_found;
    logic [IDX_W-1:0]      w_pick;
    logic [IDX_W:0]        w_sum;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_op1[g] = req_op1[g*DATA_WIDTH +: DATA_WIDTH];
        assign w_op2[g] = req_op2[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Search starts just after the last winner, so it becomes lowest priority.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_sum   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_sum = {1'b0, r_last} + (IDX_W+1)'(i);
            if (w_sum >= c_NUM) begin
                w_sum = w_sum - c_NUM;
            end
            if (!w_found && req[w_sum[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_sum[IDX_W-1:0];
            end
        end
    end

    assign w_idx_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_idx;
    assign gnt       = (r_state == c_ISSUE) ? w_idx_oh : '0;
    assign done      = (r_state == c_RESP)  ? w_idx_oh : '0;
    assign mul_start = (r_state == c_ISSUE);
    assign busy      = (r_state != c_IDLE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= c_IDLE;
            r_idx   <= '0;
            r_last  <= IDX_W'(NUM_REQ - 1);
            r_cnt   <= '0;
            result  <= '0;
            err     <= 1'b0;
            mul_op1 <= '0;
            mul_op2 <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_found) begin
                        mul_op1 <= w_op1[w_pick];
                        mul_op2 <= w_op2[w_pick];
                        r_idx   <= w_pick;
                        r_state <= c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= c_WAIT;
                end
                c_WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (mul_valid) begin
                        result  <= mul_result;
                        err     <= 1'b0;
                        r_state <= c_RESP;
                    end else if (r_cnt == c_TMO_LAST) begin
                        result  <= '0;
                        err     <= 1'b1;
                        r_state <= c_RESP;
                    end
                end
                c_RESP: begin
                    r_last  <= r_idx;
                    r_state <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mult_arbiter.sv
// ============================================================================
// Module   : tb_mult_arbiter
// Purpose  : Directed, table-driven bench for mult_arbiter with a latency-10
//            multiplier model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [3:0]  req = '0;
    logic [19:0] req_op1 = '0;
    logic [19:0] req_op2 = '0;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [9:0]  result;
    logic        err;
    logic        busy;
    logic        mul_start;
    logic [4:0]  mul_op1;
    logic [4:0]  mul_op2;
    logic [9:0]  mul_result;
    logic        mul_valid;

    logic        model_valid = 1'b0;
    logic [9:0]  model_res = '0;
    logic        spur = 1'b0;
    logic [9:0]  spur_res = '0;
    logic        mul_en = 1'b1;
    int          mcnt = 0;
    int          mul_lat = 10;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    mult_arbiter dut (
        .CLK        (CLK),
        .RST        (RST),
        .req        (req),
        .req_op1    (req_op1),
        .req_op2    (req_op2),
        .gnt        (gnt),
        .done       (done),
        .result     (result),
        .err        (err),
        .busy       (busy),
        .mul_start  (mul_start),
        .mul_op1    (mul_op1),
        .mul_op2    (mul_op2),
        .mul_result (mul_result),
        .mul_valid  (mul_valid)
    );

    // Multiplier model: answers mul_lat cycles after start; spur forces a stray valid.
    assign mul_valid  = spur ? 1'b1 : model_valid;
    assign mul_result = spur ? spur_res : model_res;

    always @(negedge CLK) begin
        model_valid = 1'b0;
        if (RST) begin
            mcnt = 0;
        end else if (mul_start) begin
            mcnt = mul_lat;
        end else if (mcnt > 0) begin
            mcnt = mcnt - 1;
            if (mcnt == 0 && mul_en) begin
                model_valid = 1'b1;
                model_res   = mul_op1 * mul_op2;
            end
        end
    end

    typedef struct {
        logic        rst_before;
        logic [3:0]  req;
        logic [19:0] op1;
        logic [19:0] op2;
        logic        hold;
        logic        mul_en;
        int          exp_idx;
        logic [9:0]  exp_res;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [19:0] pk(input int a0, input int a1, input int a2, input int a3);
        return {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        req = '0;
        RST = 1'b1;
        #1;
        check("reset_outputs", {1'b0, gnt, done, err, busy, mul_start, result, mul_op1, mul_op2}, 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic run_job(input vec_t v);
        int  w;
        bit  seen;
        bit  bok;
        if (v.rst_before) do_reset();
        mul_en  = v.mul_en;
        req     = v.req;
        req_op1 = v.op1;
        req_op2 = v.op2;
        w = 0;
        seen = 0;
        while (!seen && w < 20) begin
            @(negedge CLK);
            w++;
            if (gnt != 0) seen = 1;
        end
        if (!seen) begin
            check("gnt_timeout", 32'(gnt), 32'(1) << v.exp_idx);
            req = '0;
            return;
        end
        check("gnt", 32'(gnt), 32'(1) << v.exp_idx);
        check("gnt_latency", 32'(w), 32'd1);
        check("mul_start", 32'(mul_start), 32'd1);
        if (!v.hold) begin
            #1 req = '0;
        end
        bok = busy;
        w = 0;
        seen = 0;
        while (!seen && w < 200) begin
            @(negedge CLK);
            w++;
            if (!busy) bok = 0;
            if (done != 0) seen = 1;
        end
        if (!seen) begin
            check("done_timeout", 32'(done), 32'(1) << v.exp_idx);
            return;
        end
        check("done", 32'(done), 32'(1) << v.exp_idx);
        check("result", 32'(result), 32'(v.exp_res));
        check("err", 32'(err), 32'(v.exp_err));
        check("done_latency", 32'(w), 32'(v.exp_lat));
        check("busy_during_job", 32'(bok), 32'd1);
        @(negedge CLK);
        check("busy_after_job", {27'd0, busy, done}, 32'd0);
    endtask

    initial begin
        int  w;
        bit  seen;

        // Single job, 3*7.
        vecs[0]  = '{1'b1, 4'b0001, pk(3, 0, 0, 0),   pk(7, 0, 0, 0),   1'b0, 1'b1, 0, 10'd21,  1'b0, 11};
        // All four requesting continuously: 0,1,2,3,0.
        vecs[1]  = '{1'b1, 4'b1111, pk(2, 5, 17, 9),  pk(13, 6, 2, 31), 1'b1, 1'b1, 0, 10'd26,  1'b0, 11};
        vecs[2]  = '{1'b0, 4'b1111, pk(2, 5, 17, 9),  pk(13, 6, 2, 31), 1'b1, 1'b1, 1, 10'd30,  1'b0, 11};
        vecs[3]  = '{1'b0, 4'b1111, pk(2, 5, 17, 9),  pk(13, 6, 2, 31), 1'b1, 1'b1, 2, 10'd34,  1'b0, 11};
        vecs[4]  = '{1'b0, 4'b1111, pk(2, 5, 17, 9),  pk(13, 6, 2, 31), 1'b1, 1'b1, 3, 10'd279, 1'b0, 11};
        vecs[5]  = '{1'b0, 4'b1111, pk(2, 5, 17, 9),  pk(13, 6, 2, 31), 1'b0, 1'b1, 0, 10'd26,  1'b0, 11};
        // Requesters 0 and 2 alternate; extreme operands.
        vecs[6]  = '{1'b1, 4'b0101, pk(31, 0, 0, 0),  pk(31, 0, 17, 0), 1'b1, 1'b1, 0, 10'd961, 1'b0, 11};
        vecs[7]  = '{1'b0, 4'b0101, pk(31, 0, 0, 0),  pk(31, 0, 17, 0), 1'b1, 1'b1, 2, 10'd0,   1'b0, 11};
        vecs[8]  = '{1'b0, 4'b0101, pk(31, 0, 0, 0),  pk(31, 0, 17, 0), 1'b0, 1'b1, 0, 10'd961, 1'b0, 11};
        // Multiplier silent: watchdog abort, done TIMEOUT cycles after entering WAIT.
        vecs[9]  = '{1'b0, 4'b0010, pk(0, 3, 0, 0),   pk(0, 3, 0, 0),   1'b0, 1'b0, 1, 10'd0,   1'b1, 65};
        vecs[10] = '{1'b0, 4'b1000, pk(0, 0, 0, 4),   pk(0, 0, 0, 5),   1'b0, 1'b1, 3, 10'd20,  1'b0, 11};
        // After the mid-WAIT reset: requester 1 beats requester 2.
        vecs[11] = '{1'b0, 4'b0110, pk(0, 6, 9, 0),   pk(0, 7, 9, 0),   1'b0, 1'b1, 1, 10'd42,  1'b0, 11};

        for (int i = 0; i <= 10; i++) begin
            run_job(vecs[i]);
        end

        // Stray mul_valid in IDLE, then across the ISSUE cycle.
        @(negedge CLK);
        #1;
        spur_res = 10'd777;
        spur = 1'b1;
        repeat (3) @(negedge CLK);
        check("spur_idle_state", {28'd0, busy, 3'd0} | 32'(done), 32'd0);
        check("spur_idle_result", 32'(result), 32'd20);
        #1;
        req     = 4'b0001;
        req_op1 = pk(2, 0, 0, 0);
        req_op2 = pk(2, 0, 0, 0);
        @(negedge CLK);
        check("spur_issue_gnt", 32'(gnt), 32'd1);
        #1;
        spur = 1'b0;
        req  = '0;
        @(negedge CLK);
        check("spur_issue_state", {27'd0, busy, done}, 32'b10000);
        check("spur_issue_result", 32'(result), 32'd20);
        w = 2;
        seen = 0;
        while (!seen && w < 100) begin
            @(negedge CLK);
            if (done != 0) seen = 1;
            else w++;
        end
        check("spur_done", 32'(done), 32'd1);
        check("spur_result", 32'(result), 32'd4);
        check("spur_latency", 32'(w), 32'd11);
        @(negedge CLK);

        // Asynchronous reset in the middle of WAIT.
        #1;
        req     = 4'b0100;
        req_op1 = pk(0, 0, 5, 0);
        req_op2 = pk(0, 0, 5, 0);
        w = 0;
        seen = 0;
        while (!seen && w < 20) begin
            @(negedge CLK);
            w++;
            if (gnt != 0) seen = 1;
        end
        check("rst_job_gnt", 32'(gnt), 32'b0100);
        #1 req = '0;
        repeat (3) @(negedge CLK);
        check("rst_job_busy", 32'(busy), 32'd1);
        #1 RST = 1'b1;
        #1;
        check("async_reset_outputs", {1'b0, gnt, done, err, busy, mul_start, result, mul_op1, mul_op2}, 32'd0);
        @(negedge CLK);
        #1 RST = 1'b0;
        run_job(vecs[11]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "bench time limit");
    end

endmodule

`default_nettype wire
